// File: rtl/game_pkg.sv
// Shared definitions for the tick timer: the FSM state encoding.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle between a tick_timer and whatever commands it.
interface tick_timer_if #(
    parameter int WIDTH = 8
);
    import game_pkg::*;

    // start/clear are single-cycle strobes and pause is a level, all sampled on
    // the rising clock; there is no ready, so the timer accepts every strobe.
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             clear;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             expired;
    state_t           state;

    modport master (
        output start, load_val, pause, clear,
        input  tick, count, running, done, expired, state
    );

    modport slave (
        input  start, load_val, pause, clear,
        output tick, count, running, done, expired, state
    );

endinterface

// File: rtl/edge_sync.sv
// Synchronises the asynchronous divider level and emits a registered one-cycle
// pulse for each qualifying edge (rising only, or both when BOTH_EDGES != 0).
module edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int BOTH_EDGES  = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_raw;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_raw = sync_last ^ hist_q;
        if (BOTH_EDGES == 0) begin
            edge_raw = edge_raw & sync_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q     <= sync_last;
            edge_pulse <= edge_raw;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// Countdown timer decremented by edges of an external divider level; all
// outputs are registered so nothing flows combinationally from input to output.
module tick_timer
    import game_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BOTH_EDGES  = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         div_in,
    tick_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             edge_pulse;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_d;
    logic             tick_q, done_q, running_q, expired_q;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .BOTH_EDGES (BOTH_EDGES)
    ) u_edge_sync (
        .clock     (clock),
        .reset     (reset),
        .din       (div_in),
        .edge_pulse(edge_pulse)
    );

    // Priority: clear, then start, then pause, then the edge decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.start) begin
            if (bus.load_val == '0) begin
                state_d = ST_EXPIRED;
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = bus.load_val;
                state_d = bus.pause ? ST_PAUSED : ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (edge_pulse && (count_q != '0)) begin
                        count_d = count_q - ONE;
                        if (count_q == ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= edge_pulse;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign bus.tick    = tick_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: two instances (rising-only and both-edge) driven in
// lockstep, checked every cycle against a sample-history reference model.
module tb_tick_timer;
    import game_pkg::*;

    localparam int W = 8;
    localparam int S = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         div_in = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] load_val = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // clock / reset block
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    tick_timer_if #(.WIDTH(W)) if0 ();
    tick_timer_if #(.WIDTH(W)) if1 ();

    assign if0.start = start;  assign if1.start = start;
    assign if0.pause = pause;  assign if1.pause = pause;
    assign if0.clear = clear;  assign if1.clear = clear;
    assign if0.load_val = load_val;  assign if1.load_val = load_val;

    tick_timer #(.WIDTH(W), .SYNC_STAGES(S), .BOTH_EDGES(0)) dut0 (
        .clock(clock), .reset(reset), .div_in(div_in), .bus(if0)
    );
    tick_timer #(.WIDTH(W), .SYNC_STAGES(S), .BOTH_EDGES(1)) dut1 (
        .clock(clock), .reset(reset), .div_in(div_in), .bus(if1)
    );

    // reference model: history of div_in samples, plus per-instance timer state
    logic h [0:S+2];
    int   m_mode  [2];
    int   m_count [2];
    logic m_tick  [2];
    logic m_done  [2];

    bit auto_tog = 1'b0;
    int tog_period = 10;
    int tog_cnt = 0;

    logic [W-1:0] exp_q [$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic ev;
        if (!reset) begin
            for (int i = 0; i <= S + 2; i++) h[i] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_mode[b] = M_IDLE; m_count[b] = 0; m_tick[b] = 1'b0; m_done[b] = 1'b0;
            end
        end else begin
            for (int i = S + 2; i > 0; i--) h[i] = h[i-1];
            h[0] = div_in;
            for (int b = 0; b < 2; b++) begin
                // a level change sampled S+1 edges ago is acted on now
                ev = (b == 1) ? (h[S+1] != h[S+2]) : (h[S+1] && !h[S+2]);
                m_tick[b] = ev;
                m_done[b] = 1'b0;
                if (clear) begin
                    m_mode[b] = M_IDLE; m_count[b] = 0;
                end else if (start) begin
                    if (load_val == 0) begin
                        m_mode[b] = M_EXP; m_count[b] = 0; m_done[b] = 1'b1;
                    end else begin
                        m_count[b] = int'(load_val);
                        m_mode[b]  = pause ? M_PAUSED : M_RUN;
                    end
                end else if (m_mode[b] == M_RUN) begin
                    if (pause) m_mode[b] = M_PAUSED;
                    else if (ev) begin
                        m_count[b] = m_count[b] - 1;
                        if (m_count[b] == 0) begin
                            m_done[b] = 1'b1; m_mode[b] = M_EXP;
                        end
                    end
                end else if (m_mode[b] == M_PAUSED && !pause) begin
                    m_mode[b] = M_RUN;
                end
            end
        end
    endtask

    task automatic check_model();
        cmp("model_dut0 {tick,done,run,exp,count}",
            {if0.tick, if0.done, if0.running, if0.expired, if0.count},
            {m_tick[0], m_done[0], m_mode[0] == M_RUN, m_mode[0] == M_EXP, W'(m_count[0])});
        cmp("model_dut1 {tick,done,run,exp,count}",
            {if1.tick, if1.done, if1.running, if1.expired, if1.count},
            {m_tick[1], m_done[1], m_mode[1] == M_RUN, m_mode[1] == M_EXP, W'(m_count[1])});
    endtask

    // driver: one clock, model update at the edge, outputs sampled 1 time unit later
    task automatic step();
        if (auto_tog) begin
            if (tog_cnt == tog_period - 1) begin
                div_in  = ~div_in;
                tog_cnt = 0;
            end else begin
                tog_cnt++;
            end
        end
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic wait_tick0(input int budget, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            step();
            if (if0.tick) seen = 1'b1;
        end
        cmp({name, "_tick_seen"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic         start;
        logic [W-1:0] load;
        logic         pause;
        logic         clear;
        logic [W-1:0] e_count;
        logic         e_run;
        logic         e_exp;
        logic         e_done;
    } vec_t;

    vec_t vt [8];
    int   done_seen;
    int   ticks_p;

    initial begin
        vt[0] = '{1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        vt[1] = '{1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 8'd9,   1'b1, 1'b0, 8'd9,   1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'd0,   1'b0, 1'b0, 8'd9,   1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd9,   1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'd5,   1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'd200, 1'b0, 1'b0, 8'd200, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 8'd0,   1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0};

        // reset state
        reset = 1'b0;
        repeat (3) step();
        cmp("reset_count", 32'(if0.count), 32'd0);
        cmp("reset_flags", {if0.tick, if0.done, if0.running, if0.expired}, 32'd0);
        cmp("reset_state", 32'(if0.state), 32'(ST_IDLE));

        // div_in high at reset release: tick exactly S+1 clocks after first sample
        reset  = 1'b1;
        div_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            cmp($sformatf("latency_k%0d", k), 32'(if0.tick), 32'(k == S + 1));
        end

        // table-driven single-cycle control vectors (div_in steady)
        for (int i = 0; i < 8; i++) begin
            start = vt[i].start; load_val = vt[i].load; pause = vt[i].pause; clear = vt[i].clear;
            step();
            cmp($sformatf("vec%0d {count,run,exp,done}", i),
                {if0.count, if0.running, if0.expired, if0.done},
                {vt[i].e_count, vt[i].e_run, vt[i].e_exp, vt[i].e_done});
        end
        start = 1'b0; pause = 1'b0; clear = 1'b0;

        // countdown 3,2,1,0 on rising edges, div_in toggling every 10 clocks
        div_in = 1'b0;
        repeat (5) step();
        load_val = 8'd3; start = 1'b1; step(); start = 1'b0;
        cmp("s36_load", 32'(if0.count), 32'd3);
        exp_q = {8'd2, 8'd1, 8'd0};
        auto_tog = 1'b1; tog_period = 10; tog_cnt = 0; done_seen = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (if0.done) begin
                done_seen++;
                cmp("s36_done_count", 32'(if0.count), 32'd0);
            end
            if (if0.tick && exp_q.size() > 0) cmp("s36_tick_count", 32'(if0.count), 32'(exp_q.pop_front()));
        end
        cmp("s36_ticks_left", 32'(exp_q.size()), 32'd0);
        cmp("s36_done_once", 32'(done_seen), 32'd1);
        cmp("s36_expired", {if0.expired, if0.running}, 32'b10);

        // both-edge instance decrements twice as often; then reset mid-countdown
        auto_tog = 1'b0;
        repeat (6) step();
        load_val = 8'd6; start = 1'b1; step(); start = 1'b0;
        repeat (4) begin
            div_in = ~div_in;
            repeat (10) step();
        end
        repeat (2) step();
        cmp("s41_dut0_count", 32'(if0.count), 32'd4);
        cmp("s41_dut1_count", 32'(if1.count), 32'd2);
        reset = 1'b0; step();
        cmp("s41_rst_dut0", {if0.tick, if0.done, if0.running, if0.expired, if0.count}, 32'd0);
        cmp("s41_rst_dut1", {if1.tick, if1.done, if1.running, if1.expired, if1.count}, 32'd0);
        cmp("s41_rst_state", 32'(if0.state), 32'(ST_IDLE));
        reset = 1'b1; done_seen = 0;
        repeat (6) begin
            step();
            if (if0.done || if1.done) done_seen++;
        end
        cmp("s41_no_done", 32'(done_seen), 32'd0);

        // pause across two rising edges after the first decrement
        div_in = 1'b0;
        repeat (6) step();
        load_val = 8'd5; start = 1'b1; step(); start = 1'b0;
        auto_tog = 1'b1; tog_cnt = 0;
        wait_tick0(60, "s38_first");
        cmp("s38_first_dec", 32'(if0.count), 32'd4);
        pause = 1'b1; ticks_p = 0;
        repeat (45) begin
            step();
            if (if0.tick) ticks_p++;
        end
        cmp("s38_hold", 32'(if0.count), 32'd4);
        cmp("s38_state_paused", 32'(if0.state), 32'(ST_PAUSED));
        cmp("s38_ticks_while_paused", 32'(ticks_p >= 2), 32'd1);
        pause = 1'b0; step();
        wait_tick0(40, "s38_resume");
        cmp("s38_resume", 32'(if0.count), 32'd3);

        // clear and start with a coincident edge: clear wins
        auto_tog = 1'b0;
        repeat (6) step();
        div_in = 1'b0;
        repeat (6) step();
        load_val = 8'd3; start = 1'b1; step(); start = 1'b0;
        div_in = 1'b1; repeat (4) step();
        cmp("s40_count2", 32'(if0.count), 32'd2);
        div_in = 1'b0; repeat (5) step();
        div_in = 1'b1; repeat (3) step();
        clear = 1'b1; start = 1'b1; load_val = 8'd7; step(); clear = 1'b0;
        cmp("s40_edge_tick", 32'(if0.tick), 32'd1);
        cmp("s40_clear_count", 32'(if0.count), 32'd0);
        cmp("s40_clear_state", 32'(if0.state), 32'(ST_IDLE));
        step(); start = 1'b0;
        cmp("s40_start_alone", {if0.running, if0.count}, {1'b1, 8'd7});
        div_in = 1'b0; repeat (5) step();
        div_in = 1'b1; repeat (4) step();
        cmp("s40_next_dec", 32'(if0.count), 32'd6);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) != 0);
            clear    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 24) == 0);
            load_val = W'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            if ($urandom_range(0, 5) == 0) div_in = ~div_in;
            step();
        end
        reset = 1'b1; clear = 1'b0; start = 1'b0; pause = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
